ps2_transmitter: RTL and testbench

//  Host-to-device PS/2 transmitter, the companion of the PS/2 keyboard receiver. Sends one byte
//  (e.g. 0xED set-LEDs, 0xFF reset) to the keyboard over the shared open-drain kclk/kdata lines.
//  It inhibits the bus, issues request-to-send, then shifts data/parity/stop out on device clocks.
//  It also checks the device ACK. Sits beside the receiver; the receiver must ignore the bus while busy=1.

---
 rtl/ps2_transmitter_pkg.sv | 29 ++
 rtl/ps2_transmitter_debounce.sv | 34 +++
 rtl/ps2_transmitter.sv | 185 ++++++++++++++++++
 tb/tb_ps2_transmitter.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ps2_transmitter_pkg.sv
// Shared types and constants for the PS/2 host-to-device transmitter.
package ps2_transmitter_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_INHIBIT,
        S_RTS,
        S_SHIFT,
        S_ACK,
        S_WAIT_IDLE,
        S_DONE,
        S_ERR
    } tx_state_t;

    localparam logic [7:0] CMD_SET_LEDS = 8'hED;
    localparam logic [7:0] CMD_RESET    = 8'hFF;
    localparam logic [7:0] RSP_ACK      = 8'hFA;

    localparam int DEF_INHIBIT_CYCLES = 10_000;
    localparam int DEF_START_TIMEOUT  = 1_500_000;
    localparam int DEF_XFER_TIMEOUT   = 200_000;
    localparam int DEF_DB_COUNT_MAX   = 19;
    localparam int DEF_DB_COUNT_WIDTH = 5;

    function automatic logic odd_parity(input logic [7:0] d);
        return ~^d;
    endfunction

endpackage

// File: rtl/ps2_transmitter_debounce.sv
// Two-flop synchroniser plus stable-count filter for one PS/2 line.
module ps2_transmitter_debounce #(
    parameter int COUNT_MAX   = 19,
    parameter int COUNT_WIDTH = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic filt
);

    logic [1:0]             sync;
    logic [COUNT_WIDTH-1:0] cnt;

    // Idle PS/2 lines are pulled high, so the filter starts released.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync <= 2'b11;
            cnt  <= '0;
            filt <= 1'b1;
        end else begin
            sync <= {sync[0], raw};
            if (sync[1] == filt) begin
                cnt <= '0;
            end else if (cnt == COUNT_WIDTH'(COUNT_MAX)) begin
                filt <= sync[1];
                cnt  <= '0;
            end else begin
                cnt <= cnt + COUNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: rtl/ps2_transmitter.sv
// PS/2 host-to-device byte transmitter: inhibit, request-to-send,
// shift data/parity on device clock falls, then check the device ACK.
module ps2_transmitter
    import ps2_transmitter_pkg::*;
#(
    parameter int INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
    parameter int START_TIMEOUT  = DEF_START_TIMEOUT,
    parameter int XFER_TIMEOUT   = DEF_XFER_TIMEOUT,
    parameter int DB_COUNT_MAX   = DEF_DB_COUNT_MAX,
    parameter int DB_COUNT_WIDTH = DEF_DB_COUNT_WIDTH
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic       busy,
    output logic       tx_done,
    output logic       tx_err,
    input  logic       kclk,
    input  logic       kdata,
    output logic       kclk_low,
    output logic       kdata_low
);

    localparam int TW = $clog2(INHIBIT_CYCLES + START_TIMEOUT + XFER_TIMEOUT);

    tx_state_t     state;
    logic [8:0]    shreg;
    logic [3:0]    bit_cnt;
    logic [TW-1:0] tmo;
    logic          kclk_f;
    logic          kdata_f;
    logic          kclk_q;
    logic          fall;
    logic          xfer_exp;

    ps2_transmitter_debounce #(
        .COUNT_MAX   (DB_COUNT_MAX),
        .COUNT_WIDTH (DB_COUNT_WIDTH)
    ) u_db_kclk (
        .clk  (clk),
        .rst  (rst),
        .raw  (kclk),
        .filt (kclk_f)
    );

    ps2_transmitter_debounce #(
        .COUNT_MAX   (DB_COUNT_MAX),
        .COUNT_WIDTH (DB_COUNT_WIDTH)
    ) u_db_kdata (
        .clk  (clk),
        .rst  (rst),
        .raw  (kdata),
        .filt (kdata_f)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kclk_q <= 1'b1;
        end else begin
            kclk_q <= kclk_f;
        end
    end

    assign fall     = kclk_q & ~kclk_f;
    assign xfer_exp = (tmo == TW'(XFER_TIMEOUT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            tx_ready  <= 1'b1;
            busy      <= 1'b0;
            tx_done   <= 1'b0;
            tx_err    <= 1'b0;
            kclk_low  <= 1'b0;
            kdata_low <= 1'b0;
            shreg     <= '0;
            bit_cnt   <= '0;
            tmo       <= '0;
        end else begin
            tx_done <= 1'b0;
            tx_err  <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (tx_valid) begin
                        shreg    <= {odd_parity(tx_data), tx_data};
                        busy     <= 1'b1;
                        tx_ready <= 1'b0;
                        kclk_low <= 1'b1;
                        bit_cnt  <= '0;
                        tmo      <= '0;
                        state    <= S_INHIBIT;
                    end
                end
                S_INHIBIT: begin
                    tmo <= tmo + TW'(1);
                    // Start bit goes low while the clock is still held.
                    if (tmo == TW'(INHIBIT_CYCLES - 2)) begin
                        kdata_low <= 1'b1;
                    end
                    if (tmo == TW'(INHIBIT_CYCLES - 1)) begin
                        kclk_low  <= 1'b0;
                        kdata_low <= 1'b1;
                        tmo       <= '0;
                        state     <= S_RTS;
                    end
                end
                S_RTS: begin
                    tmo <= tmo + TW'(1);
                    if (tmo == TW'(START_TIMEOUT - 1)) begin
                        kclk_low  <= 1'b0;
                        kdata_low <= 1'b0;
                        state     <= S_ERR;
                    end else if (fall) begin
                        kdata_low <= ~shreg[0];
                        shreg     <= shreg >> 1;
                        bit_cnt   <= 4'd1;
                        tmo       <= '0;
                        state     <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    tmo <= tmo + TW'(1);
                    if (xfer_exp) begin
                        kclk_low  <= 1'b0;
                        kdata_low <= 1'b0;
                        state     <= S_ERR;
                    end else if (fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        if (bit_cnt == 4'd9) begin
                            kdata_low <= 1'b0;
                            state     <= S_ACK;
                        end else begin
                            kdata_low <= ~shreg[0];
                            shreg     <= shreg >> 1;
                        end
                    end
                end
                S_ACK: begin
                    tmo <= tmo + TW'(1);
                    if (xfer_exp) begin
                        kclk_low  <= 1'b0;
                        kdata_low <= 1'b0;
                        state     <= S_ERR;
                    end else if (fall) begin
                        bit_cnt <= bit_cnt + 4'd1;
                        state   <= kdata_f ? S_ERR : S_WAIT_IDLE;
                    end
                end
                S_WAIT_IDLE: begin
                    tmo <= tmo + TW'(1);
                    if (xfer_exp) begin
                        kclk_low  <= 1'b0;
                        kdata_low <= 1'b0;
                        state     <= S_ERR;
                    end else if (kclk_f && kdata_f) begin
                        state <= S_DONE;
                    end
                end
                S_DONE: begin
                    tx_done  <= 1'b1;
                    busy     <= 1'b0;
                    tx_ready <= 1'b1;
                    shreg    <= '0;
                    bit_cnt  <= '0;
                    tmo      <= '0;
                    state    <= S_IDLE;
                end
                S_ERR: begin
                    tx_err    <= 1'b1;
                    busy      <= 1'b0;
                    tx_ready  <= 1'b1;
                    kclk_low  <= 1'b0;
                    kdata_low <= 1'b0;
                    shreg     <= '0;
                    bit_cnt   <= '0;
                    tmo       <= '0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_transmitter.sv
// Directed bench for ps2_transmitter with a PS/2 device model on the
// wired-AND bus and a frame model computed from the byte.
module tb_ps2_transmitter;

    localparam int INH  = 50;
    localparam int ST   = 500;
    localparam int XT   = 1500;
    localparam int DB   = 3;
    localparam int HALF = 20;
    localparam int LIM  = 5000;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = '0;
    logic       tx_valid = 1'b0;
    logic       tx_ready, busy, tx_done, tx_err;
    logic       kclk_low, kdata_low;
    logic       dev_clk = 1'b1;
    logic       dev_data_low = 1'b0;
    logic       kclk_bus, kdata_bus;

    assign kclk_bus  = ~kclk_low & dev_clk;
    assign kdata_bus = ~kdata_low & ~dev_data_low;

    always #5 clk = ~clk;

    ps2_transmitter #(
        .INHIBIT_CYCLES (INH),
        .START_TIMEOUT  (ST),
        .XFER_TIMEOUT   (XT),
        .DB_COUNT_MAX   (DB),
        .DB_COUNT_WIDTH (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .tx_done   (tx_done),
        .tx_err    (tx_err),
        .kclk      (kclk_bus),
        .kdata     (kdata_bus),
        .kclk_low  (kclk_low),
        .kdata_low (kdata_low)
    );

    int errors = 0;
    int checks = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int acc = 0;
    int cyc = 0;
    int acc_cyc = 0;
    int rts_cyc = 0;
    int err_cyc = 0;
    int dev_falls = 0;
    logic [7:0]  exp_q[$];
    logic [10:0] last_frame = '0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Host-to-device frame: start 0, data LSB first, odd parity, stop 1.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        f[0] = 1'b0;
        for (int i = 0; i < 8; i++) f[i+1] = b[i];
        f[9]  = ($countones(b) % 2 == 0);
        f[10] = 1'b1;
        return f;
    endfunction

    // Per-cycle compare process.
    logic prev_done = 0, prev_err = 0, prev_kl = 0, prev_dl = 0;
    bit   exp_busy_next = 0;
    int   run = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_done = 0;
            prev_err = 0;
            prev_kl = 0;
            prev_dl = 0;
            exp_busy_next = 0;
            run = 0;
        end else begin
            cyc++;
            chk("ready_vs_busy", tx_ready, !busy);
            if (exp_busy_next) begin
                chk("accept_busy", busy, 1);
            end
            exp_busy_next = 0;
            if (tx_valid && tx_ready) begin
                exp_q.push_back(tx_data);
                acc++;
                acc_cyc = cyc;
                exp_busy_next = 1;
            end
            if (!busy) chk("idle_lines", {kclk_low, kdata_low}, 0);
            if (tx_done || tx_err) begin
                chk("pulse_excl", tx_done & tx_err, 0);
                chk("pulse_busy", busy, 0);
            end
            if (tx_done) begin
                chk("done_width", prev_done, 0);
                done_cnt++;
            end
            if (tx_err) begin
                chk("err_width", prev_err, 0);
                chk("err_lines", {kclk_low, kdata_low}, 0);
                err_cnt++;
                err_cyc = cyc;
            end
            if (prev_err) chk("ready_after_err", tx_ready, 1);
            if (kclk_low) begin
                run++;
            end else begin
                if (prev_kl) begin
                    chk("inhibit_len", run >= INH, 1);
                    chk("start_before_release", prev_dl, 1);
                    chk("accept_to_rts", cyc - acc_cyc, INH + 1);
                    rts_cyc = cyc;
                end
                run = 0;
            end
            prev_done = tx_done;
            prev_err = tx_err;
            prev_kl = kclk_low;
            prev_dl = kdata_low;
        end
    end

    // Device model: waits for RTS, clocks 11 times, samples on rise.
    task automatic dev_run(input bit ack, input bit check);
        logic [10:0] f;
        logic [7:0]  b;
        bit          ok;
        f = '0;
        ok = 0;
        for (int n = 0; n < LIM; n++) begin
            @(negedge clk);
            if (!kclk_low && kdata_low) begin
                ok = 1;
                break;
            end
        end
        chk("rts_seen", {31'b0, ok}, 1);
        if (!ok) return;
        f[0] = kdata_bus;
        repeat (30) @(negedge clk);
        for (int e = 1; e <= 11; e++) begin
            dev_clk = 1'b0;
            dev_falls++;
            repeat (HALF) @(negedge clk);
            dev_clk = 1'b1;
            if (e <= 10) f[e] = kdata_bus;
            if (e == 10 && ack) dev_data_low = 1'b1;
            if (e == 11) dev_data_low = 1'b0;
            repeat (HALF) @(negedge clk);
        end
        last_frame = f;
        chk("exp_queue", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
            b = exp_q.pop_front();
            if (check) chk("frame_model", f, model_frame(b));
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        bit ok;
        ok = 0;
        @(posedge clk);
        #1;
        tx_data = b;
        tx_valid = 1'b1;
        for (int n = 0; n < LIM; n++) begin
            @(negedge clk);
            if (tx_ready) begin
                ok = 1;
                break;
            end
        end
        chk("send_ready", {31'b0, ok}, 1);
        @(posedge clk);
        #1;
        tx_valid = 1'b0;
    endtask

    task automatic wait_pulse(input int d0, input int e0);
        bit ok;
        ok = 0;
        for (int n = 0; n < LIM; n++) begin
            if (done_cnt != d0 || err_cnt != e0) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("pulse_seen", {31'b0, ok}, 1);
        repeat (20) @(negedge clk);
    endtask

    logic [7:0]  vb [4] = '{8'hED, 8'h00, 8'hFF, 8'h01};
    logic [10:0] vf [4] = '{11'h7DA, 11'h600, 11'h7FE, 11'h402};

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int d0, e0, a0, f0;
        bit ok;
        repeat (3) @(negedge clk);
        chk("rst_ready", tx_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_done", tx_done, 0);
        chk("rst_err", tx_err, 0);
        chk("rst_kclk_low", kclk_low, 0);
        chk("rst_kdata_low", kdata_low, 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        repeat (5) @(negedge clk);

        // Normal frames with hand-computed literal frames.
        for (int i = 0; i < 4; i++) begin
            d0 = done_cnt;
            e0 = err_cnt;
            fork
                dev_run(1'b1, 1'b1);
                send_byte(vb[i]);
            join
            wait_pulse(d0, e0);
            chk("frame_literal", last_frame, vf[i]);
            chk("done_once", done_cnt - d0, 1);
            chk("no_err", err_cnt - e0, 0);
        end

        // Device never clocks: start timeout.
        d0 = done_cnt;
        e0 = err_cnt;
        send_byte(8'h11);
        wait_pulse(d0, e0);
        chk("start_tmo_err", err_cnt - e0, 1);
        chk("start_tmo_done", done_cnt - d0, 0);
        chk("start_tmo_len", (err_cyc - rts_cyc >= ST) &&
                             (err_cyc - rts_cyc <= ST + 1), 1);
        if (exp_q.size() > 0) void'(exp_q.pop_front());

        // Device withholds the ACK.
        d0 = done_cnt;
        e0 = err_cnt;
        fork
            dev_run(1'b0, 1'b1);
            send_byte(8'hA5);
        join
        wait_pulse(d0, e0);
        chk("noack_err", err_cnt - e0, 1);
        chk("noack_done", done_cnt - d0, 0);

        // Reset after the fifth device fall, then a clean send.
        d0 = done_cnt;
        e0 = err_cnt;
        f0 = dev_falls;
        fork
            dev_run(1'b1, 1'b0);
            begin
                send_byte(8'h3C);
                ok = 0;
                for (int n = 0; n < LIM; n++) begin
                    @(negedge clk);
                    if (dev_falls >= f0 + 5) begin
                        ok = 1;
                        break;
                    end
                end
                chk("fall5_seen", {31'b0, ok}, 1);
                repeat (10) @(negedge clk);
                chk("pre_rst_busy", busy, 1);
                @(posedge clk);
                #1;
                rst = 1'b1;
                @(posedge clk);
                #1;
                chk("mid_rst_kclk_low", kclk_low, 0);
                chk("mid_rst_kdata_low", kdata_low, 0);
                chk("mid_rst_ready", tx_ready, 1);
                chk("mid_rst_busy", busy, 0);
                rst = 1'b0;
            end
        join
        repeat (50) @(negedge clk);
        chk("rst_no_done", done_cnt - d0, 0);
        chk("rst_no_err", err_cnt - e0, 0);
        d0 = done_cnt;
        e0 = err_cnt;
        fork
            dev_run(1'b1, 1'b1);
            send_byte(8'hF4);
        join
        wait_pulse(d0, e0);
        chk("frame_F4", last_frame, 11'h5E8);
        chk("f4_done", done_cnt - d0, 1);

        // tx_valid held high across two IDLE visits.
        d0 = done_cnt;
        e0 = err_cnt;
        a0 = acc;
        fork
            begin
                dev_run(1'b1, 1'b1);
                dev_run(1'b1, 1'b1);
            end
            begin
                @(posedge clk);
                #1;
                tx_data = 8'h96;
                tx_valid = 1'b1;
                ok = 0;
                for (int n = 0; n < LIM; n++) begin
                    @(negedge clk);
                    if (acc >= a0 + 2) begin
                        ok = 1;
                        break;
                    end
                end
                chk("held_two_accepts", {31'b0, ok}, 1);
                @(posedge clk);
                #1;
                tx_valid = 1'b0;
            end
        join
        ok = 0;
        for (int n = 0; n < LIM; n++) begin
            if (done_cnt - d0 >= 2) begin
                ok = 1;
                break;
            end
            @(negedge clk);
        end
        chk("held_done_seen", {31'b0, ok}, 1);
        repeat (100) @(negedge clk);
        chk("held_accepts", acc - a0, 2);
        chk("held_done", done_cnt - d0, 2);
        chk("held_err", err_cnt - e0, 0);
        chk("frame_96", last_frame, 11'h72C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
